uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Memory-mapped serial transmitter on the cpu32 data bus, selected by d_addr[31:28]==4'hE.
//  Sits downstream of the CPU store path, in place of the simulation-only teleprinter.
//  CPU byte writes are queued in a small FIFO, then shifted out on tx as 8N1 frames.
//  A status word is readable on the same bus, so firmware can poll before writing.
// PARAMETERS
//  CLKDIV      16  clk cycles per serial bit; legal range 2..65535
//  DEPTH_LOG2  3   FIFO depth is 2**DEPTH_LOG2 bytes (default 8)
// PORTS
//  clk      in   1   single clock; all state changes on posedge
//  reset    in   1   asynchronous, active-low reset (0 = reset asserted)
//  cs       in   1   chip select, driven by d_addr[31:28]==4'hE
//  we       in   1   write strobe, driven by d_data_we; acts only when cs=1
//  addr     in   1   register select, driven by d_addr[2]: 0=DATA, 1=STATUS
//  wdata    in   8   write data, driven by d_data_w[7:0]
//  rdata    out  32  STATUS word; combinational, valid whenever cs=1 and addr=1, else 0
//  tx       out  1   serial line; idles high
// BEHAVIOUR
//  Reset
//   - Async assert: tx=1, FIFO empty, overflow=0, FSM=IDLE, baud and bit counters=0.
//   - Applies immediately, including in the middle of a frame; no partial stop bit is sent.
//  STATUS register: rdata = {29'b0, overflow, full, busy}
//   - busy: FIFO non-empty or FSM not in IDLE.
//   - full: FIFO count == 2**DEPTH_LOG2.
//   - overflow: sticky; set when a DATA write is dropped.
//  DATA write (cs & we & addr==0)
//   - Pushes wdata at the clock edge.
//   - If full, the write is dropped and overflow is set.
//   - Exception: a pop in the same cycle frees a slot, so the push is accepted and count is unchanged.
//  STATUS write (cs & we & addr==1)
//   - Clears overflow; wdata is ignored.
//   - If a drop occurs in the same cycle, set wins.
//  FIFO
//   - Synchronous; count has width DEPTH_LOG2+1.
//   - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
//   - Pop of an empty FIFO never occurs: the FSM gates it.
//  Transmit FSM (IDLE, START, DATA, STOP)
//   - IDLE: tx=1. If the FIFO is non-empty: pop into an 8-bit shift register, clear the baud counter, go to START.
//   - START: tx=0 for CLKDIV cycles, then go to DATA with bit index 0.
//   - DATA: tx=shift[0] for CLKDIV cycles, then shift right.
//       - After bit index 7, go to STOP.
//   - STOP: tx=1 for CLKDIV cycles, then go to IDLE.
//  Timing
//   - Frame length is exactly 10*CLKDIV cycles.
//   - Back-to-back frames have a 1-cycle IDLE gap (the pop cycle).
//   - Write-to-start-bit latency: write at edge N, pop at edge N+1, tx=0 from just after edge N+1.
//   - tx is a registered output; it has no combinational path from the inputs.
//  Arithmetic
//   - Baud counter is 16 bits and counts 0..CLKDIV-1.
//   - Terminal count is CLKDIV-1; the counter reloads to 0 on every state change.
// STRUCTURE
//  Shared include uart_defs.vh
//   - FSM state encodings (2 bits).
//   - STATUS bit positions: ST_BUSY=0, ST_FULL=1, ST_OVF=2.
//   - Register select values: REG_DATA=0, REG_STATUS=1.
//  Sub-module fifo_sync #(WIDTH, DEPTH_LOG2)
//   - Ports: clk, reset, push, pop, wdata, rdata, count.
//   - Output rdata is the head entry, not registered.
//  Top level: FIFO instance, baud counter, bit counter, shift register, FSM, STATUS mux.
//  Target size ~200 lines of RTL total.
// TESTING (CLKDIV=4, DEPTH_LOG2=3; the bench samples tx each cycle and decodes frames)
//  1. Reset with reset=0 for 2 cycles, then release -> tx=1 and STATUS reads 32'h0.
//  2. Write DATA 8'h41 -> tx=0 from one edge after the write.
//       Check: bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 4 cycles high.
//       Check: busy=0 exactly 40 cycles after the pop, and the decoder reports 0x41.
//  3. Ten back-to-back DATA writes 0x00..0x09 -> writes 1..9 accepted, 0x09 dropped.
//       Check: full=1 after write 9 and overflow=1 after write 10.
//       Check: the decoder reports 0x00..0x08 in order.
//  4. After test 3, write STATUS -> overflow=0 next cycle, while full and busy are unchanged.
//  5. Assert reset during DATA bit 3 of a frame, with 3 bytes queued.
//       Check: tx=1 immediately (asynchronous), STATUS=0, and no further frames after release.
//  6. Fill the FIFO to full, then write DATA in the exact IDLE pop cycle.
//       Check: write accepted, overflow stays 0, and the byte is transmitted last.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encodings,
// STATUS bit positions and register-select values.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  function automatic logic [31:0] pack_status(input logic ovf, input logic full, input logic busy);
    logic [31:0] s;
    s          = '0;
    s[ST_BUSY] = busy;
    s[ST_FULL] = full;
    s[ST_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo_sync.sv
// Small synchronous FIFO with a combinational head output; the caller never
// pushes into a full FIFO unless it pops in the same cycle.
module fifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;

  // Storage carries no reset; only the pointers define which entries are live.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == DEPTH_LOG2'(gi))) begin
          mem[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 serial transmitter: CPU byte writes are queued in a FIFO
// and shifted out on tx; a STATUS word lets firmware poll busy/full/overflow.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKDIV     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic        addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0] BAUD_LAST = 16'(CLKDIV - 1);

  tx_state_e             state_reg;
  logic [15:0]           baud_reg;
  logic [2:0]            bit_reg;
  logic [7:0]            shift_reg;
  logic                  tx_reg;
  logic                  ovf_reg;

  logic [DEPTH_LOG2:0]   fifo_count;
  logic [7:0]            fifo_head;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  full;
  logic                  busy;
  logic                  data_wr;
  logic                  status_wr;
  logic                  drop;
  logic                  baud_done;

  assign data_wr   = cs & we & (addr == REG_DATA);
  assign status_wr = cs & we & (addr == REG_STATUS);
  assign full      = (fifo_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign fifo_pop  = (state_reg == ST_IDLE) && (fifo_count != '0);
  // A pop in the same cycle frees the slot the write needs, so it is not a drop.
  assign fifo_push = data_wr & (~full | fifo_pop);
  assign drop      = data_wr & full & ~fifo_pop;
  assign baud_done = (baud_reg == BAUD_LAST);
  assign busy      = (fifo_count != '0) || (state_reg != ST_IDLE);

  fifo_sync #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wdata),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (fifo_pop) begin
            shift_reg <= fifo_head;
            baud_reg  <= '0;
            tx_reg    <= 1'b0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            tx_reg    <= shift_reg[0];
            state_reg <= ST_DATA;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              // tx is registered, so it takes the next bit ahead of the shift.
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
              bit_reg   <= bit_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= ST_IDLE;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a STATUS write leaves overflow set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (status_wr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign rdata = (cs && (addr == REG_STATUS)) ? pack_status(ovf_reg, full, busy) : 32'h0;
  assign tx    = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a timeline model (byte queue plus remaining-frame
// time) predicts tx and STATUS every cycle; a line decoder recovers bytes.
module tb_uart_tx_fifo;

  localparam int CLKDIV     = 4;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int FRAME      = 10 * CLKDIV;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        cs    = 1'b1;
  logic        we    = 1'b0;
  logic        addr  = 1'b1;
  logic [7:0]  wdata = 8'h00;
  logic [31:0] rdata;
  logic        tx;

  uart_tx_fifo #(
    .CLKDIV     (CLKDIV),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes waiting, bytes sent, and time left in the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] dec_q[$];
  logic [7:0] m_cur   = 8'h00;
  int         m_left  = 0;
  logic       m_ovf   = 1'b0;
  int         dec_cnt = -1;
  logic [7:0] dec_byte = 8'h00;

  function automatic logic exp_tx();
    int k;
    if (m_left == 0) return 1'b1;
    k = (FRAME - m_left) / CLKDIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic [31:0] exp_status();
    return {29'b0, m_ovf, (m_q.size() == DEPTH), (m_q.size() > 0 || m_left > 0)};
  endfunction

  task automatic model_reset();
    if (m_left > 0 && (FRAME - m_left) < 9 * CLKDIV + CLKDIV / 2) void'(m_sent.pop_back());
    m_q.delete();
    m_left  = 0;
    m_ovf   = 1'b0;
    dec_cnt = -1;
  endtask

  task automatic decode();
    int j;
    if (dec_cnt < 0) begin
      if (tx === 1'b0) dec_cnt = 0;
    end else begin
      dec_cnt++;
    end
    if (dec_cnt >= 0 && (dec_cnt % CLKDIV) == CLKDIV / 2) begin
      j = dec_cnt / CLKDIV;
      if (j == 0) begin
        if (tx !== 1'b0) dec_cnt = -1;
      end else if (j <= 8) begin
        dec_byte[j-1] = tx;
      end else begin
        chk("stop_bit", 32'(tx), 32'd1);
        dec_q.push_back(dec_byte);
        $display("frame decoded 0x%02h", dec_byte);
        dec_cnt = -1;
      end
    end
  endtask

  task automatic tick();
    logic pop;
    logic drop;
    logic push_req;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      push_req = cs && we && !addr;
      pop      = (m_left == 0) && (m_q.size() > 0);
      drop     = push_req && (m_q.size() == DEPTH) && !pop;
      if (m_left > 0) m_left--;
      if (pop) begin
        m_cur  = m_q.pop_front();
        m_left = FRAME;
        m_sent.push_back(m_cur);
      end
      if (push_req && !drop) m_q.push_back(wdata);
      if (drop) m_ovf = 1'b1;
      else if (cs && we && addr) m_ovf = 1'b0;
    end
    #1;
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("rdata", rdata, (cs && addr) ? exp_status() : 32'h0);
    if (reset) decode();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    $display("write %s 0x%02h", a ? "STATUS" : "DATA", d);
    tick();
    cs = 1'b1; we = 1'b0; addr = 1'b1;
  endtask

  task automatic status_now(output logic [31:0] s);
    cs = 1'b1; we = 1'b0; addr = 1'b1;
    #1;
    s = rdata;
  endtask

  task automatic drain();
    int g = 0;
    while ((m_q.size() > 0 || m_left > 0) && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) chk("drain_timeout", 32'd1, 32'd0);
    idle(3);
  endtask

  initial begin
    logic [31:0] s;
    logic [9:0]  pat;
    int          base;
    int          guard;
    int          r;

    // 1. reset
    idle(2);
    reset = 1'b1;
    tick();
    status_now(s);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_status", s, 32'h0);

    // 2. single byte 0x41
    base = dec_q.size();
    pat  = {1'b1, 8'h41, 1'b0};
    wr(1'b0, 8'h41);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      chk("t2_bit", 32'(tx), 32'(pat[c / CLKDIV]));
      if (c == 20) begin
        cs = 1'b0;
        #1;
        chk("t2_rdata_cs0", rdata, 32'h0);
        cs = 1'b1;
      end
    end
    status_now(s);
    chk("t2_busy_last", 32'(s[0]), 32'd1);
    tick();
    status_now(s);
    chk("t2_busy_end", 32'(s[0]), 32'd0);
    chk("t2_dec_count", 32'(dec_q.size() - base), 32'd1);
    if (dec_q.size() > base) chk("t2_dec", 32'(dec_q[base]), 32'h41);
    idle(2);

    // 3. ten back-to-back writes, the tenth is dropped
    base = dec_q.size();
    for (int i = 0; i < 10; i++) begin
      wr(1'b0, 8'(i));
      status_now(s);
      if (i == 8) begin
        chk("t3_full", 32'(s[1]), 32'd1);
        chk("t3_ovf_before", 32'(s[2]), 32'd0);
      end
      if (i == 9) chk("t3_ovf", 32'(s[2]), 32'd1);
    end

    // 4. STATUS write clears overflow only
    wr(1'b1, 8'hFF);
    status_now(s);
    chk("t4_status", s, 32'h3);
    drain();
    chk("t3_dec_count", 32'(dec_q.size() - base), 32'd9);
    for (int i = 0; i < 9; i++)
      if (base + i < dec_q.size()) chk("t3_dec", 32'(dec_q[base + i]), 32'(i));

    // 5. asynchronous reset during DATA bit 3 with three bytes queued
    for (int i = 0; i < 4; i++) wr(1'b0, 8'h00);
    guard = 0;
    while (m_left != FRAME - 17 && guard < 200) begin
      tick();
      guard++;
    end
    chk("t5_reach_bit3", 32'(guard < 200), 32'd1);
    base  = dec_q.size();
    reset = 1'b0;
    #1;
    chk("t5_tx_async", 32'(tx), 32'd1);
    chk("t5_status_async", rdata, 32'h0);
    model_reset();
    idle(2);
    reset = 1'b1;
    idle(100);
    status_now(s);
    chk("t5_status_after", s, 32'h0);
    chk("t5_no_frames", 32'(dec_q.size()), 32'(base));

    // 6. write while full in the exact pop cycle
    for (int i = 0; i < 9; i++) wr(1'b0, 8'h10 + 8'(i));
    status_now(s);
    chk("t6_full", 32'(s[1]), 32'd1);
    guard = 0;
    while (!(m_left == 0 && m_q.size() > 0) && guard < 100) begin
      tick();
      guard++;
    end
    chk("t6_reach_pop", 32'(guard < 100), 32'd1);
    wr(1'b0, 8'hA5);
    status_now(s);
    chk("t6_status", s, 32'h3);
    drain();
    if (dec_q.size() > 0) chk("t6_last", 32'(dec_q[dec_q.size() - 1]), 32'hA5);

    // randomized bus traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          cs = 1'b1; we = 1'b1; addr = 1'b0; wdata = 8'($urandom);
          $display("write DATA 0x%02h", wdata);
        end
        2: begin
          cs = 1'b1; we = 1'b1; addr = 1'b1; wdata = 8'($urandom);
          $display("write STATUS 0x%02h", wdata);
        end
        3: begin
          cs = 1'b0; we = 1'b1; addr = 1'($urandom_range(0, 1)); wdata = 8'($urandom);
        end
        default: begin
          cs = 1'($urandom_range(0, 1)); we = 1'b0; addr = 1'($urandom_range(0, 1));
        end
      endcase
      tick();
    end
    cs = 1'b1; we = 1'b0; addr = 1'b1;
    drain();

    chk("dec_total", 32'(dec_q.size()), 32'(m_sent.size()));
    for (int i = 0; i < dec_q.size() && i < m_sent.size(); i++)
      chk("dec_byte", 32'(dec_q[i]), 32'(m_sent[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
